// File: rtl/fifo_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : fifo_pipe_pkg
// Brief  : Shared select encodings and occupancy states for the FIFO pipeline.
// Rev    : 1.0
// ============================================================================
package fifo_pipe_pkg;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LOAD  = 2'b01;
  localparam logic [1:0] SEL_SHIFT = 2'b10;
  localparam logic [1:0] SEL_CLR   = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PART  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : fifo_pipe_ctrl_if
// Brief  : Handshake, select and status bundle; FIFO_PIPE_CTRL_STATS_EN adds counters.
// Rev    : 1.0
// ============================================================================
interface fifo_pipe_ctrl_if #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic                 flush;
  logic [2*DEPTH-1:0]   sel;
  logic [DEPTH-1:0]     stage_full;
  logic [CW-1:0]        count;
  logic                 fifo_full;
  logic                 fifo_empty;
`ifdef FIFO_PIPE_CTRL_STATS_EN
  logic [7:0]           drop_cnt;
  logic [7:0]           uflow_cnt;
`endif

  modport master (
    input  in_valid, out_ready, flush,
    output in_ready, out_valid, sel, stage_full, count, fifo_full, fifo_empty
`ifdef FIFO_PIPE_CTRL_STATS_EN
    , output drop_cnt, uflow_cnt
`endif
  );

  modport slave (
    output in_valid, out_ready, flush,
    input  in_ready, out_valid, sel, stage_full, count, fifo_full, fifo_empty
`ifdef FIFO_PIPE_CTRL_STATS_EN
    , input drop_cnt, uflow_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/fifo_pipe_ctrl_stage_sel_dec.sv
`default_nettype none
// ============================================================================
// Module : stage_sel_dec
// Brief  : Combinational mux-select decode for one pipeline stage.
// Rev    : 1.0
// ============================================================================
module stage_sel_dec
  import fifo_pipe_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic          rst,
  input  logic [CW-1:0] idx,
  input  logic [CW-1:0] count,
  output logic [1:0]    sel
);
  // One extra bit so idx+1 cannot wrap when comparing against the tail.
  logic [CW:0] w_idx_p1;
  logic        w_below_tail;
  logic        w_at_tail;
  logic        w_at_free;

  assign w_idx_p1     = {1'b0, idx} + {{CW{1'b0}}, 1'b1};
  assign w_below_tail = (w_idx_p1 <  {1'b0, count});
  assign w_at_tail    = (w_idx_p1 == {1'b0, count});
  assign w_at_free    = (idx == count);

  always_comb begin
    sel = SEL_HOLD;
    if (rst || flush) begin
      sel = SEL_CLR;
    end else if (pop) begin
      if (w_below_tail) begin
        sel = SEL_SHIFT;
      end else if (w_at_tail) begin
        sel = push ? SEL_LOAD : SEL_CLR;
      end
    end else if (push && w_at_free) begin
      sel = SEL_LOAD;
    end
  end
endmodule
`default_nettype wire

// File: rtl/fifo_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fifo_pipe_ctrl
// Brief  : Occupancy sequencer for an N-stage shift-register FIFO pipeline.
//          Define FIFO_PIPE_CTRL_STATS_EN for drop/underflow counters.
// Rev    : 1.0
// ============================================================================
module fifo_pipe_ctrl
  import fifo_pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  fifo_pipe_ctrl_if.master  bus
);
  localparam logic [CW-1:0] c_last_cnt = CW'(DEPTH - 1);
  localparam logic [CW-1:0] c_one_cnt  = CW'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [DEPTH-1:0] r_stage_full;
  logic [DEPTH-1:0] w_stage_full_nxt;
  logic             w_push;
  logic             w_pop;

  assign bus.in_ready   = (r_state != ST_FULL) && !bus.flush && !rst;
  assign bus.out_valid  = r_stage_full[0];
  assign bus.fifo_full  = (r_state == ST_FULL);
  assign bus.fifo_empty = (r_state == ST_EMPTY);
  assign bus.count      = r_count;
  assign bus.stage_full = r_stage_full;

  assign w_push = bus.in_valid  && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_count      <= '0;
      r_stage_full <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_stage_full <= w_stage_full_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_stage_full_nxt = r_stage_full;
    if (bus.flush) begin
      w_state_nxt      = ST_EMPTY;
      w_count_nxt      = '0;
      w_stage_full_nxt = '0;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_push) w_state_nxt = ST_PART;
        ST_PART: begin
          if (w_push && !w_pop && (r_count == c_last_cnt)) w_state_nxt = ST_FULL;
          else if (w_pop && !w_push && (r_count == c_one_cnt)) w_state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (w_pop) w_state_nxt = ST_PART;
        default:  w_state_nxt = ST_EMPTY;
      endcase
      // Occupancy stays a thermometer: grow at the tail, shrink from the tail.
      if (w_push && !w_pop) begin
        w_count_nxt      = r_count + c_one_cnt;
        w_stage_full_nxt = {r_stage_full[DEPTH-2:0], 1'b1};
      end else if (w_pop && !w_push) begin
        w_count_nxt      = r_count - c_one_cnt;
        w_stage_full_nxt = {1'b0, r_stage_full[DEPTH-1:1]};
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    stage_sel_dec #(
      .CW (CW)
    ) u_dec (
      .push  (w_push),
      .pop   (w_pop),
      .flush (bus.flush),
      .rst   (rst),
      .idx   (CW'(gi)),
      .count (r_count),
      .sel   (bus.sel[2*gi+1:2*gi])
    );
  end

`ifdef FIFO_PIPE_CTRL_STATS_EN
  logic [7:0] r_drop_cnt;
  logic [7:0] r_uflow_cnt;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_drop_cnt  <= '0;
      r_uflow_cnt <= '0;
    end else begin
      if (bus.in_valid && bus.fifo_full && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;
      if (bus.out_ready && bus.fifo_empty && (r_uflow_cnt != 8'hFF))
        r_uflow_cnt <= r_uflow_cnt + 8'd1;
    end
  end

  assign bus.drop_cnt  = r_drop_cnt;
  assign bus.uflow_cnt = r_uflow_cnt;
`endif
endmodule
`default_nettype wire
